// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded operand/destination info in, stall/flush/forward controls out.
// The master side is the control unit (or bench); the slave side is hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 32
);
    localparam int FWD_W = $clog2(PIPE_DEPTH + 1);

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  redirect;

    logic                  stall;
    logic                  flush;
    logic [FWD_W-1:0]      fwd_a_sel;
    logic [FWD_W-1:0]      fwd_b_sel;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dst, id_reg_write, id_mem_read, redirect,
        input  stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dst, id_reg_write, id_mem_read, redirect,
        output stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: shift-register scoreboard of in-flight writers.
// Define HAZARD_FWD_EN to enable operand forwarding (stall only on load-use).
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int PIPE_DEPTH   = 3,
    parameter int REDIRECT_IDX = 1,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hz
);
    localparam int FWD_W = $clog2(PIPE_DEPTH + 1);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  is_load;
    } entry_t;

    entry_t           sb_q [PIPE_DEPTH];
    entry_t           sb_d [PIPE_DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [PIPE_DEPTH-1:0] match_a, match_b;
    logic                  hazard;
    logic                  stall;
    logic [FWD_W-1:0]      fwd_a, fwd_b;

    // Register 0 is hardwired, so an entry targeting it never matches.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            match_a[k] = sb_q[k].valid && (sb_q[k].dst != '0) &&
                         (sb_q[k].dst == hz.id_rs) && hz.id_rs_used;
            match_b[k] = sb_q[k].valid && (sb_q[k].dst != '0) &&
                         (sb_q[k].dst == hz.id_rt) && hz.id_rt_used;
        end
    end

    always_comb begin
        hazard = 1'b0;
        fwd_a  = '0;
        fwd_b  = '0;
`ifdef HAZARD_FWD_EN
        hazard = sb_q[0].is_load && (match_a[0] || match_b[0]);
        // Walk oldest to youngest so the youngest non-stalling producer wins.
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (match_a[k] && !(k == 0 && sb_q[0].is_load)) fwd_a = FWD_W'(k + 1);
            if (match_b[k] && !(k == 0 && sb_q[0].is_load)) fwd_b = FWD_W'(k + 1);
        end
`else
        hazard = |{match_a, match_b};
`endif
    end

`ifndef HAZARD_FWD_EN
    logic [PIPE_DEPTH-1:0] unused_is_load;
    always_comb begin
        unused_is_load = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) unused_is_load[k] = sb_q[k].is_load;
    end
`endif

    assign stall        = hz.id_valid && hazard && !hz.redirect;
    assign hz.stall     = stall;
    assign hz.flush     = hz.redirect;
    assign hz.fwd_a_sel = fwd_a;
    assign hz.fwd_b_sel = fwd_b;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

    always_comb begin
        for (int k = 1; k < PIPE_DEPTH; k++) sb_d[k] = sb_q[k-1];
        sb_d[0] = '{valid:   hz.id_valid && hz.id_reg_write && (hz.id_dst != '0),
                    dst:     hz.id_dst,
                    is_load: hz.id_mem_read};
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (hz.redirect) begin
            // Everything younger than the resolving stage is on the wrong path.
            for (int k = 0; k <= REDIRECT_IDX; k++) sb_d[k].valid = 1'b0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall) begin
            sb_d[0].valid = 1'b0;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the scoreboard is control state, so every entry is reset, not just the counters.
            for (int k = 0; k < PIPE_DEPTH; k++) sb_q[k] <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: queue-based pipeline model, directed cases, then random traffic.
// Two DUTs share stimulus: full-width counters and CNT_W = 2 for saturation.
module tb_hazard_scoreboard;
    localparam int AW  = 5;
    localparam int PD  = 3;
    localparam int RI  = 1;
    localparam int CW  = 32;
    localparam int CWS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(AW), .PIPE_DEPTH(PD), .CNT_W(CW))  m_if ();
    hazard_scoreboard_if #(.REG_ADDR_W(AW), .PIPE_DEPTH(PD), .CNT_W(CWS)) s_if ();

    hazard_scoreboard #(.REG_ADDR_W(AW), .PIPE_DEPTH(PD), .REDIRECT_IDX(RI), .CNT_W(CW))
        dut (.clk(clk), .rst(rst), .hz(m_if));
    hazard_scoreboard #(.REG_ADDR_W(AW), .PIPE_DEPTH(PD), .REDIRECT_IDX(RI), .CNT_W(CWS))
        dut_small (.clk(clk), .rst(rst), .hz(s_if));

    assign s_if.id_valid     = m_if.id_valid;
    assign s_if.id_rs        = m_if.id_rs;
    assign s_if.id_rt        = m_if.id_rt;
    assign s_if.id_rs_used   = m_if.id_rs_used;
    assign s_if.id_rt_used   = m_if.id_rt_used;
    assign s_if.id_dst       = m_if.id_dst;
    assign s_if.id_reg_write = m_if.id_reg_write;
    assign s_if.id_mem_read  = m_if.id_mem_read;
    assign s_if.redirect     = m_if.redirect;

    // Reference model: a queue of in-flight writers, youngest at the front.
    typedef struct { bit v; int dst; bit ld; } rec_t;
    typedef struct {
        bit stall; bit flush; int fa; int fb;
        longint sc; longint fc; longint scs; longint fcs;
    } exp_t;

    rec_t        pipe [$];
    exp_t        exp_q [$];
    int unsigned m_scnt = 0;
    int unsigned m_fcnt = 0;
    bit          known  = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit hit(input int p, input int src, input bit used);
        return used && (src != 0) && pipe[p].v && (pipe[p].dst == src);
    endfunction

    function automatic int fwd_of(input int src, input bit used);
        for (int p = 0; p < PD; p++)
            if (hit(p, src, used) && !(p == 0 && pipe[0].ld)) return p + 1;
        return 0;
    endfunction

    function automatic longint sat(input int unsigned c, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (longint'(c) > mx) ? mx : longint'(c);
    endfunction

    task automatic drive(input bit r, input bit v, input int rs, input int rt,
                         input bit rsu, input bit rtu, input int dst,
                         input bit rw, input bit mr, input bit rd);
        bit   haz;
        bit   st;
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        m_if.id_valid     = v;
        m_if.id_rs        = AW'(rs);
        m_if.id_rt        = AW'(rt);
        m_if.id_rs_used   = rsu;
        m_if.id_rt_used   = rtu;
        m_if.id_dst       = AW'(dst);
        m_if.id_reg_write = rw;
        m_if.id_mem_read  = mr;
        m_if.redirect     = rd;
        if (known) begin
            haz = 1'b0;
            e.fa = 0;
            e.fb = 0;
`ifdef HAZARD_FWD_EN
            haz  = pipe[0].ld && (hit(0, rs, rsu) || hit(0, rt, rtu));
            e.fa = fwd_of(rs, rsu);
            e.fb = fwd_of(rt, rtu);
`else
            for (int p = 0; p < PD; p++) if (hit(p, rs, rsu) || hit(p, rt, rtu)) haz = 1'b1;
`endif
            st      = v && haz && !rd;
            e.stall = st;
            e.flush = rd;
            e.sc    = sat(m_scnt, CW);
            e.fc    = sat(m_fcnt, CW);
            e.scs   = sat(m_scnt, CWS);
            e.fcs   = sat(m_fcnt, CWS);
            exp_q.push_back(e);
            if (!r) begin
                if (rd) begin
                    m_fcnt++;
                    pipe.push_front('{1'b0, 0, 1'b0});
                    for (int p = 0; p <= RI; p++) pipe[p].v = 1'b0;
                end else if (st) begin
                    m_scnt++;
                    pipe.push_front('{1'b0, 0, 1'b0});
                end else begin
                    pipe.push_front('{v && rw && (dst != 0), dst, mr});
                end
                pipe.delete(pipe.size() - 1);
            end
        end
        if (r) begin
            pipe.delete();
            for (int p = 0; p < PD; p++) pipe.push_back('{1'b0, 0, 1'b0});
            m_scnt = 0;
            m_fcnt = 0;
            known  = 1'b1;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writer(input int dst, input bit ld);
        drive(0, 1, 0, 0, 0, 0, dst, 1, ld, 0);
    endtask

    task automatic reader(input int src);
        drive(0, 1, src, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // Holds a reader of src in ID until it is released; reports stall count and first unstalled fwd_a.
    task automatic hold_reader(input int src, output int n, output int fa_first, output int fa_free);
        n        = 0;
        fa_first = -1;
        fa_free  = -1;
        for (int i = 0; i < 6; i++) begin
            reader(src);
            @(negedge clk);
            if (i == 0) fa_first = int'(m_if.fwd_a_sel);
            if (m_if.stall) n++;
            else begin
                fa_free = int'(m_if.fwd_a_sel);
                break;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stall",           m_if.stall,     e.stall);
                check("flush",           m_if.flush,     e.flush);
                check("fwd_a_sel",       m_if.fwd_a_sel, e.fa);
                check("fwd_b_sel",       m_if.fwd_b_sel, e.fb);
                check("stall_cnt",       m_if.stall_cnt, e.sc);
                check("flush_cnt",       m_if.flush_cnt, e.fc);
                check("stall_cnt_small", s_if.stall_cnt, e.scs);
                check("flush_cnt_small", s_if.flush_cnt, e.fcs);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n, fa_first, fa_free;
        logic [CW-1:0] sc0;
        rst               = 1'b1;
        m_if.id_valid     = 1'b0;
        m_if.id_rs        = '0;
        m_if.id_rt        = '0;
        m_if.id_rs_used   = 1'b0;
        m_if.id_rt_used   = 1'b0;
        m_if.id_dst       = '0;
        m_if.id_reg_write = 1'b0;
        m_if.id_mem_read  = 1'b0;
        m_if.redirect     = 1'b0;

        // Reset for two cycles, then quiet.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        @(negedge clk);
        check("rst_stall",     m_if.stall,     0);
        check("rst_flush",     m_if.flush,     0);
        check("rst_fwd_a",     m_if.fwd_a_sel, 0);
        check("rst_fwd_b",     m_if.fwd_b_sel, 0);
        check("rst_stall_cnt", m_if.stall_cnt, 0);
        check("rst_flush_cnt", m_if.flush_cnt, 0);

        // ALU producer r3 followed by a reader of r3.
        writer(3, 0);
        hold_reader(3, n, fa_first, fa_free);
`ifdef HAZARD_FWD_EN
        check("alu_use_stalls", n, 0);
        check("alu_use_fwd_a",  fa_first, 1);
        check("alu_use_cnt",    m_if.stall_cnt, 0);
`else
        check("alu_use_stalls", n, 3);
        check("alu_use_fwd_a",  fa_first, 0);
        check("alu_use_cnt",    m_if.stall_cnt, 3);
`endif

        // Load r5 followed by a reader of r5.
        writer(5, 1);
        hold_reader(5, n, fa_first, fa_free);
`ifdef HAZARD_FWD_EN
        check("load_use_stalls", n, 1);
        check("load_use_fwd_a",  fa_free, 2);
        check("load_use_cnt",    m_if.stall_cnt, 1);
`else
        check("load_use_stalls", n, 3);
        check("load_use_fwd_a",  fa_free, 0);
        check("load_use_cnt",    m_if.stall_cnt, 6);
`endif

        // Writer of r0 then a reader of r0 on both ports.
        drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("r0_stall", m_if.stall,     0);
        check("r0_fwd_a", m_if.fwd_a_sel, 0);
        check("r0_fwd_b", m_if.fwd_b_sel, 0);

        // Redirect in the same cycle as a load-use hazard.
        idle();
        idle();
        idle();
        writer(6, 1);
        drive(0, 1, 6, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("redir_stall", m_if.stall, 0);
        check("redir_flush", m_if.flush, 1);
        sc0 = m_if.stall_cnt;
        reader(6);
        @(negedge clk);
        check("redir_flush_cnt", m_if.flush_cnt, 1);
        check("redir_stall_cnt", m_if.stall_cnt, sc0);
        check("redir_killed",    m_if.stall,     0);
        check("redir_fwd_a",     m_if.fwd_a_sel, 0);
        check("redir_flush_off", m_if.flush,     0);

        // Pile up stalls so the 2-bit counters saturate.
        for (int j = 0; j < 4; j++) begin
            writer(7, 1);
            hold_reader(7, n, fa_first, fa_free);
        end
        check("sat_small_stall", s_if.stall_cnt, 3);
        check("sat_small_flush", s_if.flush_cnt, 1);
`ifdef HAZARD_FWD_EN
        check("sat_full_stall", m_if.stall_cnt, 5);
`else
        check("sat_full_stall", m_if.stall_cnt, 18);
`endif

        // Reset asserted while a stall is active.
        writer(7, 1);
        drive(1, 1, 7, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("midrst_stall_before", m_if.stall, 1);
        reader(7);
        @(negedge clk);
        check("midrst_stall",     m_if.stall,     0);
        check("midrst_stall_cnt", m_if.stall_cnt, 0);
        check("midrst_flush_cnt", m_if.flush_cnt, 0);
        check("midrst_small_cnt", s_if.stall_cnt, 0);

        // Random traffic over a small register range for a high hazard rate.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(99) == 0, $urandom_range(7) != 0,
                  $urandom_range(4), $urandom_range(4),
                  $urandom_range(1), $urandom_range(1),
                  $urandom_range(4), $urandom_range(3) != 0,
                  $urandom_range(2) == 0, $urandom_range(7) == 0);
        end
        idle();

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
